mem_access_initiator: RTL

// - M-stage load/store initiator: takes the CPU's memory access (lw/lh/lhu/lb/lbu/sw/sh/sb) and issues it
//   as a req/ack transaction to an external multi-cycle data memory (the responder side of the bus).
// - Stalls the pipeline while a transaction is outstanding; aligns store lanes and sign/zero-extends load data.
// - Sits between the M-stage RT forwarding mux output and the W-stage register-file write-data mux.

---
 rtl/mem_access_initiator_if.sv | 24 ++
 rtl/mem_access_initiator.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_initiator_if.sv
// Data-memory bus between the M-stage load/store initiator and a multi-cycle
// responder. The initiator holds bus_req and every request field steady until
// bus_ack. bus_ack is a single-cycle pulse, and bus_rdata is valid in that same cycle.
interface mem_access_initiator_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [3:0]        bus_be;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access_initiator.sv
// M-stage load/store initiator. It turns lw/lh/lhu/lb/lbu/sw/sh/sb into one
// req/ack bus transaction and stalls the pipeline while that transaction is
// outstanding. It also builds the store lane enables and data, and
// sign- or zero-extends load data for the W stage.
// FSM: IDLE -> REQ -> DONE -> IDLE. DONE is the one cycle in which the pipeline
// advances. During DONE the same instruction is still present at the inputs,
// so the FSM must not accept a request there.
// Optional feature: define MEM_TRACE_EN to print each acked store.
// The logic is the same whether or not the macro is defined.
module mem_access_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] MemAddr,
    input  logic [31:0]       MemWD,
    input  logic [1:0]        MemType,
    input  logic              MemSignExt,
    input  logic [31:0]       PCPlus4_M,
    output logic              Stall,
    output logic [31:0]       MemOut,
    output logic              AddrErr,
    output logic              BusErr,
    mem_access_initiator_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    // Last REQ-cycle count before giving up. This value is only used when
    // TIMEOUT_CYCLES != 0.
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [1:0]        type_q, type_d;
    logic [1:0]        lane_q, lane_d;
    logic              sx_q, sx_d;
    logic [31:0]       out_q, out_d;
    logic              berr_q, berr_d;
    logic [31:0]       cnt_q, cnt_d;

    logic              is_word, is_half, go, expired;
    logic [3:0]        be_in;
    logic [31:0]       wdata_in;

    // Select the addressed lane of the returned word, then extend it to 32 bits.
    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] typ,
                                           input logic [1:0] lane, input logic sx);
        logic [15:0] h;
        logic [7:0]  b;
        h = lane[1] ? w[31:16] : w[15:0];
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        case (typ)
            2'b01:   extend = {{16{sx & h[15]}}, h};
            2'b10:   extend = {{24{sx & b[7]}}, b};
            default: extend = w;
        endcase
    endfunction

    // Decode the access size, detect misalignment, and build the store lanes.
    always_comb begin
        is_word  = (MemType == 2'b00) || (MemType == 2'b11);
        is_half  = (MemType == 2'b01);
        AddrErr  = (is_word && (MemAddr[1:0] != 2'b00)) || (is_half && MemAddr[0]);
        go       = (MemRead || MemWrite) && !AddrErr;
        Stall    = ((state_q == IDLE) && go) || (state_q == REQ);
        expired  = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
        if (is_word) begin
            be_in    = 4'b1111;
            wdata_in = MemWD;
        end else if (is_half) begin
            be_in    = MemAddr[1] ? 4'b1100 : 4'b0011;
            wdata_in = {2{MemWD[15:0]}};
        end else begin
            be_in    = 4'b0001 << MemAddr[1:0];
            wdata_in = {4{MemWD[7:0]}};
        end
    end

    // Next-state logic. The bus fields are captured once, on entry to REQ,
    // and then held until the transaction ends.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        type_d  = type_q;
        lane_d  = lane_q;
        sx_d    = sx_q;
        out_d   = out_q;
        berr_d  = berr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                berr_d = 1'b0;
                if (go) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = MemWrite;
                    addr_d  = {MemAddr[ADDR_W-1:2], 2'b00};
                    wdata_d = wdata_in;
                    be_d    = be_in;
                    type_d  = MemType;
                    lane_d  = MemAddr[1:0];
                    sx_d    = MemSignExt;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 32'd1;
                if (bus.bus_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    out_d   = extend(bus.bus_rdata, type_q, lane_q, sx_q);
                    berr_d  = 1'b0;
                end else if (expired) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    out_d   = '0;
                    berr_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                berr_d  = 1'b0;
            end
        endcase
    end

    // State register. Reset also drops a request that is in flight.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            type_q  <= '0;
            lane_q  <= '0;
            sx_q    <= 1'b0;
            out_q   <= '0;
            berr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            type_q  <= type_d;
            lane_q  <= lane_d;
            sx_q    <= sx_d;
            out_q   <= out_d;
            berr_q  <= berr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_be    = be_q;
    assign MemOut        = out_q;
    assign BusErr        = berr_q;

`ifdef MEM_TRACE_EN
    // Print each store as it is acked. The pipeline is stalled during REQ,
    // so the PC and byte address at the inputs still belong to this store.
    always_ff @(posedge CLK) begin
        if (Reset && (state_q == REQ) && bus.bus_ack && we_q)
            $display("%d@%h: *%h <= %h", $time, PCPlus4_M - 32'd4, MemAddr,
                     wdata_q & {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}});
    end
`else
    logic unused_trace;
    assign unused_trace = ^PCPlus4_M;
`endif
endmodule
